// File: rtl/fp_div_pkg.sv
// rtl/fp_div_pkg.sv - FP32 field constants, flag indices and sequencer state encoding.
package fp_div_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_W    = 23;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  localparam int FLG_INV = 0;
  localparam int FLG_DBZ = 1;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fp32_classify.sv
// rtl/fp32_classify.sv - combinational IEEE-754 single-precision operand classifier.
module fp32_classify
  import fp_div_pkg::*;
(
  input  logic [31:0] op,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan,
  output logic        is_denorm
);

  logic [EXP_MSB-EXP_LSB:0] expo;
  logic [MAN_W-1:0]         man;

  assign expo = op[EXP_MSB:EXP_LSB];
  assign man  = op[MAN_W-1:0];

  assign is_zero   = (expo == '0) && (man == '0);
  assign is_denorm = (expo == '0) && (man != '0);
  assign is_inf    = (expo == '1) && (man == '0);
  assign is_nan    = (expo == '1) && (man != '0);

endmodule

// File: rtl/fp_div_sequencer.sv
// rtl/fp_div_sequencer.sv - multicycle controller in front of a combinational FP32 divider.
// FP_DIV_STICKY_FLAGS_EN adds flags_clr / sticky_flags accumulation.
module fp_div_sequencer
  import fp_div_pkg::*;
#(
  parameter int DIV_CYCLES = 4,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags
`ifdef FP_DIV_STICKY_FLAGS_EN
  ,
  input  logic        flags_clr,
  output logic [3:0]  sticky_flags
`endif
);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             accept;

  logic a_zero, a_inf, a_nan, a_den;
  logic b_zero, b_inf, b_nan, b_den;
  logic a_z, b_z, sign;
  logic        is_special;
  logic [31:0] sp_result;
  logic [3:0]  sp_flags;
  logic [3:0]  norm_flags;

  fp32_classify u_class_a (.op(in_a), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan), .is_denorm(a_den));
  fp32_classify u_class_b (.op(in_b), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan), .is_denorm(b_den));

  // Denormals are flushed to signed zero before deciding the special case.
  assign a_z  = a_zero | a_den;
  assign b_z  = b_zero | b_den;
  assign sign = in_a[SIGN_BIT] ^ in_b[SIGN_BIT];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    is_special = 1'b1;
    sp_result  = '0;
    sp_flags   = '0;
    if (a_nan || b_nan || (a_z && b_z) || (a_inf && b_inf)) begin
      sp_result         = QNAN;
      sp_flags[FLG_INV] = 1'b1;
    end else if (a_inf) begin
      sp_result = {sign, POS_INF[30:0]};
    end else if (b_z) begin
      sp_result         = {sign, POS_INF[30:0]};
      sp_flags[FLG_DBZ] = 1'b1;
    end else if (b_inf || a_z) begin
      sp_result = {sign, 31'b0};
    end else begin
      is_special = 1'b0;
    end
  end

  always_comb begin
    norm_flags          = '0;
    norm_flags[FLG_OVF] = (div_result[EXP_MSB:EXP_LSB] == '1);
    norm_flags[FLG_UNF] = (div_result[EXP_MSB:EXP_LSB] == '0) && (div_result[30:0] != '0);
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = is_special ? DONE : WAIT;
          cnt_next   = CNT_W'(DIV_CYCLES - 1);
        end
      end
      WAIT: begin
        if (cnt == '0) state_next = DONE;
        else           cnt_next   = cnt - 1'b1;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_a      <= '0;
      div_b      <= '0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (accept) begin
      div_a <= in_a;
      div_b <= in_b;
      if (is_special) begin
        out_result <= sp_result;
        out_flags  <= sp_flags;
      end
    end else if (state == WAIT && cnt == '0) begin
      out_result <= div_result;
      out_flags  <= norm_flags;
    end
  end

`ifdef FP_DIV_STICKY_FLAGS_EN
  // A clear coinciding with a handshake also drops that handshake's flags.
  always_ff @(posedge clk) begin
    if (rst || flags_clr)          sticky_flags <= '0;
    else if (out_valid && out_ready) sticky_flags <= sticky_flags | out_flags;
  end
`endif

endmodule

// File: tb/tb_fp_div_sequencer.sv
// tb/tb_fp_div_sequencer.sv - self-checking bench for fp_div_sequencer with a table-driven Div model.
module tb_fp_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b, div_a, div_b, div_result, out_result;
  logic        out_valid, out_ready;
  logic [3:0]  out_flags;
`ifdef FP_DIV_STICKY_FLAGS_EN
  logic        flags_clr;
  logic [3:0]  sticky_flags;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
  } exp_t;

  vec_t vecs[14];
  vec_t hold_vec;
  exp_t sb[$];

  always #5 clk = ~clk;

  fp_div_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .div_a(div_a), .div_b(div_b), .div_result(div_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
`ifdef FP_DIV_STICKY_FLAGS_EN
    , .flags_clr(flags_clr), .sticky_flags(sticky_flags)
`endif
  );

  function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3F800000_3F800000: return 32'h3F800000;
      64'h3F800000_3FC00000: return 32'h3F2AAAAB;
      64'hBFA00000_3FC00000: return 32'hBF555555;
      64'h42FE1000_41878000: return 32'h40F00000;
      64'h7F000000_3E800000: return 32'h7F800000;
      64'h00800000_40000000: return 32'h00400000;
      default:               return 32'hDEADBEEF;
    endcase
  endfunction

  assign div_result = div_model(div_a, div_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", out_result);
      end else begin
        e = sb.pop_front();
        chk("sb_result", out_result, e.res);
        chk("sb_flags", {28'b0, out_flags}, {28'b0, e.flags});
      end
    end
  end

  task automatic do_txn(input vec_t v, input int hold, input bit noise);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_a      = v.a;
    in_b      = v.b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    sb.push_back('{v.res, v.flags});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("div_a", div_a, v.a);
    chk("div_b", div_b, v.b);
    if (noise) begin
      in_valid = 1'b1;
      in_a     = 32'h12345678;
      in_b     = 32'h9ABCDEF0;
    end
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (noise) chk("held_div_a", div_a, v.a);
    end
    in_valid = 1'b0;
    chk("latency", lat, v.lat);
    chk("in_ready_busy", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_result", out_result, v.res);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_drop", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 5};
    vecs[1]  = '{32'h3F800000, 32'h3FC00000, 32'h3F2AAAAB, 4'b0000, 5};
    vecs[2]  = '{32'hBFA00000, 32'h3FC00000, 32'hBF555555, 4'b0000, 5};
    vecs[3]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0010, 1};
    vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0001, 1};
    vecs[5]  = '{32'hC0000000, 32'h7F800000, 32'h80000000, 4'b0000, 1};
    vecs[6]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0001, 1};
    vecs[7]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b0001, 1};
    vecs[8]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1};
    vecs[9]  = '{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 1};
    vecs[10] = '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 1};
    vecs[11] = '{32'h3F800000, 32'h80000001, 32'hFF800000, 4'b0010, 1};
    vecs[12] = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0100, 5};
    vecs[13] = '{32'h00800000, 32'h40000000, 32'h00400000, 4'b1000, 5};
    hold_vec = '{32'h42FE1000, 32'h41878000, 32'h40F00000, 4'b0000, 5};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
`ifdef FP_DIV_STICKY_FLAGS_EN
    flags_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_div_a", div_a, 0);
    chk("rst_div_b", div_b, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_flags", {28'b0, out_flags}, 0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) do_txn(vecs[i], 0, (i == 1));

    do_txn(hold_vec, 3, 1'b0);

    // Reset during the second WAIT cycle must discard the transaction.
    in_a      = 32'h3F800000;
    in_b      = 32'h3FC00000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_div_a", div_a, 0);
    chk("mid_rst_div_b", div_b, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_rst_quiet", out_valid, 0);

`ifdef FP_DIV_STICKY_FLAGS_EN
    chk("sticky_after_rst", {28'b0, sticky_flags}, 0);
    do_txn(vecs[3], 0, 1'b0);
    do_txn(vecs[4], 0, 1'b0);
    chk("sticky_accum", {28'b0, sticky_flags}, 32'h3);
    in_a      = 32'h3F800000;
    in_b      = 32'h00000000;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    sb.push_back('{32'h7F800000, 4'b0010});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("sticky_txn_valid", out_valid, 1);
    flags_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    flags_clr = 1'b0;
    chk("sticky_clear_wins", {28'b0, sticky_flags}, 0);
    chk("sticky_txn_done", out_valid, 0);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_div_sequencer.md
Name: fp_div_sequencer

Overview:
- Multicycle controller placed directly upstream of the combinational FP32 divider `Div`.
- Accepts an operand pair over a valid/ready handshake and registers it onto the divider inputs.
- Holds those inputs stable for DIV_CYCLES clocks, then captures the divider result into a registered output with valid/ready and exception flags.
- IEEE special cases are resolved locally and bypass the wait.

Parameters:
- DIV_CYCLES, 4, clocks the operands are held before `div_result` is sampled (legal range 1..7).
- CNT_W, 3, width of the settle counter; must satisfy 2^CNT_W > DIV_CYCLES.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair.
- in_a  in  32  dividend, IEEE-754 single.
- in_b  in  32  divisor, IEEE-754 single.
- div_a  out  32  registered dividend to the `Div` A input.
- div_b  out  32  registered divisor to the `Div` B input.
- div_result  in  32  `Div` output.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  32  quotient.
- out_flags  out  4  {underflow, overflow, div_by_zero, invalid}.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; counter=0.
  - div_a, div_b, out_result, out_flags = 0; out_valid=0.
  - Reset mid-WAIT or mid-DONE discards the transaction with no output.
- in_ready = (state==IDLE). One transaction in flight; no overlap.
- IDLE, on in_valid && in_ready:
  - Register in_a/in_b into div_a/div_b.
  - Classify both operands. Denormals are flushed to signed zero for classification.
  - Special → DONE with bypass result. Otherwise → WAIT with counter = DIV_CYCLES-1.
- Special cases; sign = a[31]^b[31] unless stated:
  - a or b NaN → 32'h7FC00000, invalid.
  - 0/0 or inf/inf → 32'h7FC00000, invalid.
  - finite nonzero / 0 → signed inf, div_by_zero.
  - inf / finite → signed inf, no flag.
  - finite / inf → signed zero.
  - 0 / finite nonzero → signed zero.
- WAIT:
  - div_a/div_b held constant.
  - Counter decrements each clock.
  - On the clock where counter==0: latch div_result into out_result and go to DONE.
  - Normal-path flags: overflow = (exponent==8'hFF); underflow = (exponent==0 and result ≠ ±0); invalid = div_by_zero = 0.
- DONE:
  - out_valid=1; out_result/out_flags stable while out_ready=0.
  - On out_ready → IDLE with out_valid=0.
  - A new pair is accepted no earlier than the cycle after the handshake.
- Latency, measured from the accept edge:
  - Normal path: out_valid is high DIV_CYCLES+1 clocks after the accept edge (DIV_CYCLES=4 → 5).
  - Special path: out_valid is high 1 clock after the accept edge.
- Edge cases:
  - in_valid in any state other than IDLE is ignored; the upstream must hold its pair.
  - DIV_CYCLES=1: WAIT lasts exactly one clock.

Optional Feature:
- Macro: FP_DIV_STICKY_FLAGS_EN.
- Defined:
  - Adds input flags_clr (1) and output sticky_flags (4), reset to 0.
  - On every out_valid && out_ready, sticky_flags |= out_flags.
  - flags_clr zeroes sticky_flags. If it coincides with a handshake, the clear wins and the new flags are also dropped.
- Undefined: both ports and the register are absent; all other behaviour is identical.

Decomposition:
- Package fp_div_pkg holds:
  - FP32 field constants (SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MAN_W=23).
  - QNAN=32'h7FC00000, POS_INF=32'h7F800000.
  - Flag bit indices FLG_INV=0, FLG_DBZ=1, FLG_OVF=2, FLG_UNF=3.
  - State encoding IDLE/WAIT/DONE.
- One natural sub-module: fp32_classify, combinational.
  - Input: 32-bit operand.
  - Outputs: is_zero, is_inf, is_nan, is_denorm.
  - Instantiated twice, for a and b.

Test Plan:
- 1.0/1.0 (3F800000/3F800000) with a `Div` model and DIV_CYCLES=4 → out_valid at accept+5, out_result 3F800000, flags 0.
- 1.0/1.5 (3F800000/3FC00000) → 3F2AAAAB; then -1.25/1.5 (BFA00000/3FC00000) → BF555555. Checks back-to-back issue, with in_ready low until DONE completes.
- 127.03125/16.9375 (42FE1000/41878000) with out_ready held low 3 cycles → out_result 40F00000 stays stable, single handshake, then in_ready=1.
- 1.0/0 → 7F800000, flags 4'b0010, latency 1. 0/0 → 7FC00000, flags 4'b0001. -2.0/+inf → 80000000, flags 0.
- rst asserted in the 2nd WAIT cycle of 3F800000/3FC00000 → next cycle IDLE, out_valid=0, div_a=div_b=0, and no result ever emitted.
- With FP_DIV_STICKY_FLAGS_EN: 1/0 then 0/0 → sticky_flags 4'b0011; flags_clr on the same cycle as a third handshake → 0.
